config_ctrl: RTL and testbench
==============================

CONFIG_CTRL -- requirements
Module: config_ctrl

Interface
- REQ-001 SHALL have parameter CONFIG_WIDTH, default 2: Addr and Data width.
- REQ-002 SHALL have parameter PORCH_WIDTH, default 8: porch output width.
- REQ-003 SHALL have parameter REZ_WIDTH, default 11: active-count output width.
- REQ-004 SHALL have parameter REZ_MAX_WIDTH, default 11: max-count output width.
- REQ-005 SHALL have ports:
  - Clk  in  1  sole clock; all logic on its rising edge.
  - Rst  in  1  reset, synchronous, active-low.
  - Valid  in  1  write strobe.
  - Addr  in  CONFIG_WIDTH  command select.
  - Data  in  CONFIG_WIDTH  mode index.
  - Load_config  out  1  one-cycle "new timing present" pulse.
  - H_front_porch, H_back_porch, V_front_porch, V_back_porch  out  PORCH_WIDTH each.
  - H_count_max, V_count_max  out  REZ_MAX_WIDTH each.
  - H_count_activ, V_count_activ  out  REZ_WIDTH each.

Function
- REQ-006 SHALL accept a command only on a rising edge with Valid=1; Valid=0 ignores Addr/Data entirely.
- REQ-007 SHALL decode Addr:
  - 00: no-op.
  - 01: stage Data into the shadow mode register.
  - 10: apply Data as the active mode.
  - 11: apply the shadow mode as the active mode.
- REQ-008 SHALL map mode index to timing; each entry lists active / FP / BP / total:
  - 0 = 640x480: H 640/16/48/800, V 480/10/33/525.
  - 1 = 800x600: H 800/40/88/1056, V 600/1/23/628.
  - 2 = 1024x768: H 1024/24/160/1344, V 768/3/29/806.
  - 3 = 1280x1024: H 1280/48/248/1688, V 1024/1/38/1066.
- REQ-009 SHALL drive *_count_activ = active and *_count_max = total-1 (e.g. H_count_max=799 for mode 0).
- REQ-010 SHALL drive all timing outputs from registers; latency is one cycle from the accepting edge to the new values.
- REQ-011 SHALL assert Load_config for exactly one cycle, coincident with the first cycle the new values are present.
- REQ-012 SHALL apply and pulse even when the applied mode equals the current mode.
- REQ-013 SHALL handle back-to-back applies: one update and one pulse per accepted apply, so Load_config may stay high on consecutive cycles.
- REQ-014 SHALL keep outputs and the shadow register stable between applies; Addr 00 and 01 never pulse Load_config.
- REQ-015 SHALL, for Addr 11, use the shadow value held before that edge.

Reset
- REQ-016 SHALL, while Rst=0 at a clock edge, set active and shadow mode to 0, outputs to mode-0 values, Load_config=0, and ignore Valid.
- REQ-017 SHALL pulse Load_config once in the first cycle after Rst returns high, with mode-0 values.
- REQ-018 SHALL let reset mid-operation override any command in the same cycle; no pending update survives.

Configuration
- REQ-019 SHALL support macro CONFIG_STAGED_EN.
  - Defined: Addr 01/11 behave per REQ-007.
  - Undefined: shadow register absent; Addr 01 and 11 are no-ops; Addr 10 is unchanged.

Structure
- REQ-020 SHALL place width defaults, the Addr command encodings and the four-mode timing constants in shared package config_pkg.
- REQ-021 SHALL use one combinational sub-module config_preset_rom (mode index in, eight timing values out); config_ctrl registers its outputs.

Verification
- REQ-022 Reset: Rst=0 two cycles then 1 -> mode-0 values (H_count_max=799, V_count_max=524); Load_config=1 for one cycle after release.
- REQ-023 Valid=0 with Addr=10/Data=11, then Addr=11/Data=10 -> outputs unchanged, Load_config stays 0.
- REQ-024 Valid=1, Addr=10, Data=11 -> next cycle H_count_activ=1280, H_back_porch=248, V_count_max=1065, one-cycle pulse.
- REQ-025 Consecutive Addr=10 applies with Data=01 then Data=10 -> 800x600 values then 1024x768 values (H_count_max=1343), Load_config high two cycles.
- REQ-026 With CONFIG_STAGED_EN: Addr=01/Data=01 -> no change, no pulse; then Addr=11 -> 800x600 values with pulse. Without the macro: both commands are no-ops.
- REQ-027 Rst=0 asserted in the same cycle as an Addr=10/Data=10 write -> mode-0 values, no pulse until release.

Source files
------------

// File: rtl/config_pkg.sv
// Shared widths, Addr command encodings and the four video-mode timing tables
// for the config_ctrl slice.
package config_pkg;

  localparam int unsigned CFG_CONFIG_WIDTH  = 2;
  localparam int unsigned CFG_PORCH_WIDTH   = 8;
  localparam int unsigned CFG_REZ_WIDTH     = 11;
  localparam int unsigned CFG_REZ_MAX_WIDTH = 11;

  localparam logic [1:0] CMD_NOP          = 2'b00;
  localparam logic [1:0] CMD_STAGE        = 2'b01;
  localparam logic [1:0] CMD_APPLY        = 2'b10;
  localparam logic [1:0] CMD_APPLY_SHADOW = 2'b11;

  // Index: 0=640x480, 1=800x600, 2=1024x768, 3=1280x1024
  localparam int unsigned H_ACTIVE [4] = '{640, 800, 1024, 1280};
  localparam int unsigned H_FP     [4] = '{16, 40, 24, 48};
  localparam int unsigned H_BP     [4] = '{48, 88, 160, 248};
  localparam int unsigned H_TOTAL  [4] = '{800, 1056, 1344, 1688};
  localparam int unsigned V_ACTIVE [4] = '{480, 600, 768, 1024};
  localparam int unsigned V_FP     [4] = '{10, 1, 3, 1};
  localparam int unsigned V_BP     [4] = '{33, 23, 29, 38};
  localparam int unsigned V_TOTAL  [4] = '{525, 628, 806, 1066};

endpackage

// File: rtl/config_preset_rom.sv
// Combinational mode-index to timing lookup; count_max values are total-1.
module config_preset_rom
  import config_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH  = CFG_CONFIG_WIDTH,
  parameter int unsigned PORCH_WIDTH   = CFG_PORCH_WIDTH,
  parameter int unsigned REZ_WIDTH     = CFG_REZ_WIDTH,
  parameter int unsigned REZ_MAX_WIDTH = CFG_REZ_MAX_WIDTH
) (
  input  logic [CONFIG_WIDTH-1:0]  mode,
  output logic [PORCH_WIDTH-1:0]   h_front_porch,
  output logic [PORCH_WIDTH-1:0]   h_back_porch,
  output logic [PORCH_WIDTH-1:0]   v_front_porch,
  output logic [PORCH_WIDTH-1:0]   v_back_porch,
  output logic [REZ_MAX_WIDTH-1:0] h_count_max,
  output logic [REZ_MAX_WIDTH-1:0] v_count_max,
  output logic [REZ_WIDTH-1:0]     h_count_activ,
  output logic [REZ_WIDTH-1:0]     v_count_activ
);

  logic [1:0] idx;

  always_comb begin
    idx           = 2'(mode);
    h_front_porch = PORCH_WIDTH'(H_FP[idx]);
    h_back_porch  = PORCH_WIDTH'(H_BP[idx]);
    v_front_porch = PORCH_WIDTH'(V_FP[idx]);
    v_back_porch  = PORCH_WIDTH'(V_BP[idx]);
    h_count_max   = REZ_MAX_WIDTH'(H_TOTAL[idx] - 1);
    v_count_max   = REZ_MAX_WIDTH'(V_TOTAL[idx] - 1);
    h_count_activ = REZ_WIDTH'(H_ACTIVE[idx]);
    v_count_activ = REZ_WIDTH'(V_ACTIVE[idx]);
  end

endmodule

// File: rtl/config_ctrl.sv
// Video timing configuration register with one-cycle Load_config strobe.
// Optional shadow (stage/apply-shadow) commands enabled by `define CONFIG_STAGED_EN.
module config_ctrl
  import config_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH  = CFG_CONFIG_WIDTH,
  parameter int unsigned PORCH_WIDTH   = CFG_PORCH_WIDTH,
  parameter int unsigned REZ_WIDTH     = CFG_REZ_WIDTH,
  parameter int unsigned REZ_MAX_WIDTH = CFG_REZ_MAX_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Valid,
  input  logic [CONFIG_WIDTH-1:0]  Addr,
  input  logic [CONFIG_WIDTH-1:0]  Data,
  output logic                     Load_config,
  output logic [PORCH_WIDTH-1:0]   H_front_porch,
  output logic [PORCH_WIDTH-1:0]   H_back_porch,
  output logic [PORCH_WIDTH-1:0]   V_front_porch,
  output logic [PORCH_WIDTH-1:0]   V_back_porch,
  output logic [REZ_MAX_WIDTH-1:0] H_count_max,
  output logic [REZ_MAX_WIDTH-1:0] V_count_max,
  output logic [REZ_WIDTH-1:0]     H_count_activ,
  output logic [REZ_WIDTH-1:0]     V_count_activ
);

  logic [CONFIG_WIDTH-1:0]  active_mode, next_mode, rom_mode;
  logic                     apply, load_pending;
  logic [PORCH_WIDTH-1:0]   rom_hfp, rom_hbp, rom_vfp, rom_vbp;
  logic [REZ_MAX_WIDTH-1:0] rom_hmax, rom_vmax;
  logic [REZ_WIDTH-1:0]     rom_hact, rom_vact;
`ifdef CONFIG_STAGED_EN
  logic [CONFIG_WIDTH-1:0]  shadow_mode;
`endif

  always_comb begin
    apply     = 1'b0;
    next_mode = active_mode;
    if (Valid) begin
      case (2'(Addr))
        CMD_APPLY: begin
          apply     = 1'b1;
          next_mode = Data;
        end
`ifdef CONFIG_STAGED_EN
        CMD_APPLY_SHADOW: begin
          apply     = 1'b1;
          next_mode = shadow_mode;
        end
`endif
        default: ;
      endcase
    end
    // Reset forces the lookup to mode 0 so the registered outputs land there too
    rom_mode = Rst ? next_mode : '0;
  end

  config_preset_rom #(
    .CONFIG_WIDTH  (CONFIG_WIDTH),
    .PORCH_WIDTH   (PORCH_WIDTH),
    .REZ_WIDTH     (REZ_WIDTH),
    .REZ_MAX_WIDTH (REZ_MAX_WIDTH)
  ) u_rom (
    .mode          (rom_mode),
    .h_front_porch (rom_hfp),
    .h_back_porch  (rom_hbp),
    .v_front_porch (rom_vfp),
    .v_back_porch  (rom_vbp),
    .h_count_max   (rom_hmax),
    .v_count_max   (rom_vmax),
    .h_count_activ (rom_hact),
    .v_count_activ (rom_vact)
  );

  always_ff @(posedge Clk) begin
    H_front_porch <= rom_hfp;
    H_back_porch  <= rom_hbp;
    V_front_porch <= rom_vfp;
    V_back_porch  <= rom_vbp;
    H_count_max   <= rom_hmax;
    V_count_max   <= rom_vmax;
    H_count_activ <= rom_hact;
    V_count_activ <= rom_vact;
    if (!Rst) begin
      active_mode  <= '0;
      load_pending <= 1'b1;
      Load_config  <= 1'b0;
`ifdef CONFIG_STAGED_EN
      shadow_mode  <= '0;
`endif
    end else begin
      active_mode  <= next_mode;
      // load_pending produces the single post-reset strobe announcing mode 0
      load_pending <= 1'b0;
      Load_config  <= apply | load_pending;
`ifdef CONFIG_STAGED_EN
      if (Valid && (2'(Addr) == CMD_STAGE)) shadow_mode <= Data;
`endif
    end
  end

endmodule

// File: tb/tb_config_ctrl.sv
// Directed self-checking bench for config_ctrl (default and CONFIG_STAGED_EN builds).
module tb_config_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Valid;
  logic [1:0]  Addr;
  logic [1:0]  Data;
  logic        Load_config;
  logic [7:0]  H_front_porch, H_back_porch, V_front_porch, V_back_porch;
  logic [10:0] H_count_max, V_count_max, H_count_activ, V_count_activ;

  int passes = 0;
  int checks = 0;

  config_ctrl dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Valid         (Valid),
    .Addr          (Addr),
    .Data          (Data),
    .Load_config   (Load_config),
    .H_front_porch (H_front_porch),
    .H_back_porch  (H_back_porch),
    .V_front_porch (V_front_porch),
    .V_back_porch  (V_back_porch),
    .H_count_max   (H_count_max),
    .V_count_max   (V_count_max),
    .H_count_activ (H_count_activ),
    .V_count_activ (V_count_activ)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, let the rising edge take them, sample on the falling edge
  task automatic step(input logic rst, input logic v, input logic [1:0] a, input logic [1:0] d);
    Rst = rst; Valid = v; Addr = a; Data = d;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input int mode, input logic load);
    int hact, hfp, hbp, htot, vact, vfp, vbp, vtot;
    case (mode)
      0: begin hact = 640;  hfp = 16; hbp = 48;  htot = 800;  vact = 480;  vfp = 10; vbp = 33; vtot = 525;  end
      1: begin hact = 800;  hfp = 40; hbp = 88;  htot = 1056; vact = 600;  vfp = 1;  vbp = 23; vtot = 628;  end
      2: begin hact = 1024; hfp = 24; hbp = 160; htot = 1344; vact = 768;  vfp = 3;  vbp = 29; vtot = 806;  end
      default: begin hact = 1280; hfp = 48; hbp = 248; htot = 1688; vact = 1024; vfp = 1; vbp = 38; vtot = 1066; end
    endcase
    cmp({tag, ".load"},  int'(Load_config),   int'(load));
    cmp({tag, ".hact"},  int'(H_count_activ), hact);
    cmp({tag, ".hfp"},   int'(H_front_porch), hfp);
    cmp({tag, ".hbp"},   int'(H_back_porch),  hbp);
    cmp({tag, ".hmax"},  int'(H_count_max),   htot - 1);
    cmp({tag, ".vact"},  int'(V_count_activ), vact);
    cmp({tag, ".vfp"},   int'(V_front_porch), vfp);
    cmp({tag, ".vbp"},   int'(V_back_porch),  vbp);
    cmp({tag, ".vmax"},  int'(V_count_max),   vtot - 1);
  endtask

  initial begin
    Rst = 1'b0; Valid = 1'b0; Addr = 2'b00; Data = 2'b00;
    @(negedge Clk);

    step(0, 0, 2'b00, 2'b00);
    step(0, 1, 2'b10, 2'b11);
    check("reset_hold", 0, 1'b0);
    step(1, 0, 2'b00, 2'b00);
    check("reset_release", 0, 1'b1);
    step(1, 0, 2'b00, 2'b00);
    check("post_release_idle", 0, 1'b0);

    step(1, 0, 2'b10, 2'b11);
    check("invalid_apply", 0, 1'b0);
    step(1, 0, 2'b11, 2'b10);
    check("invalid_apply_shadow", 0, 1'b0);

    step(1, 1, 2'b10, 2'b11);
    check("apply_mode3", 3, 1'b1);
    step(1, 0, 2'b00, 2'b00);
    check("mode3_hold", 3, 1'b0);

    step(1, 1, 2'b10, 2'b01);
    check("b2b_mode1", 1, 1'b1);
    step(1, 1, 2'b10, 2'b10);
    check("b2b_mode2", 2, 1'b1);
    step(1, 1, 2'b10, 2'b10);
    check("reapply_same", 2, 1'b1);
    step(1, 1, 2'b00, 2'b11);
    check("valid_nop", 2, 1'b0);

    step(1, 1, 2'b01, 2'b01);
    check("stage_mode1", 2, 1'b0);
    step(1, 1, 2'b11, 2'b00);
`ifdef CONFIG_STAGED_EN
    check("apply_shadow", 1, 1'b1);
`else
    check("apply_shadow_nop", 2, 1'b0);
`endif
    step(1, 0, 2'b00, 2'b00);

    step(0, 1, 2'b10, 2'b10);
    check("reset_over_apply", 0, 1'b0);
    step(0, 0, 2'b00, 2'b00);
    check("reset_hold2", 0, 1'b0);
    step(1, 0, 2'b00, 2'b00);
    check("reset_release2", 0, 1'b1);

    step(1, 1, 2'b11, 2'b11);
`ifdef CONFIG_STAGED_EN
    check("shadow_after_reset", 0, 1'b1);
`else
    check("shadow_after_reset_nop", 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
